// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with runtime signed/unsigned mode.
// start is accepted only in IDLE; done pulses once per result and product holds until the next result.
module seq_multiplier #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   result;
    logic                 last_step;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // One iteration: conditional add into the upper half, then shift {carry, acc} right.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_step  = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
        result    = neg ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
        last_step = (state == CALC) && (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (state == IDLE && start) begin
                mcand  <= mag_a;
                mplier <= mag_b;
                neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc_step;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            if (last_step) begin
                product <= result;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances sharing clock and reset.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int tests;
    int failures;

    typedef struct {
        int          w;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    // Issue one operation, scramble operands after the sampling edge, wait for done.
    task automatic run_op(input int w, input logic sm, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int edges, output int busy_n);
        @(negedge clk);
        if (w == 4) begin
            sm4 = sm; a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1;
        end else begin
            sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
        end
        @(posedge clk);
        edges  = 1;
        busy_n = 0;
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        a4  = 4'($urandom_range(0, 15));
        b4  = 4'($urandom_range(0, 15));
        sm4 = 1'($urandom_range(0, 1));
        a8  = 8'($urandom_range(0, 255));
        b8  = 8'($urandom_range(0, 255));
        sm8 = 1'($urandom_range(0, 1));
        while (!cur_done(w) && edges < 40) begin
            if (cur_busy(w)) busy_n++;
            @(negedge clk);
            edges++;
        end
        p = (w == 4) ? {8'h00, prod4} : prod8;
        @(negedge clk);
        check("done_one_cycle", 32'(cur_done(w)), 32'd0);
    endtask

    initial begin
        logic [15:0] p;
        int          edges;
        int          busy_n;
        int          n;
        int          held_bad;
        int          done_seen;

        tests    = 0;
        failures = 0;
        rst_n  = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;

        vecs.push_back(vec_t'{4, 1'b0, 8'd3,  8'd5,  16'h000F});
        vecs.push_back(vec_t'{4, 1'b0, 8'd15, 8'd15, 16'h00E1});
        vecs.push_back(vec_t'{4, 1'b0, 8'd0,  8'd10, 16'h0000});
        vecs.push_back(vec_t'{4, 1'b0, 8'd8,  8'd8,  16'h0040});
        vecs.push_back(vec_t'{4, 1'b0, 8'd15, 8'd1,  16'h000F});
        vecs.push_back(vec_t'{4, 1'b1, 8'hD,  8'd5,  16'h00F1});
        vecs.push_back(vec_t'{4, 1'b1, 8'h5,  8'hD,  16'h00F1});
        vecs.push_back(vec_t'{4, 1'b1, 8'h8,  8'h8,  16'h0040});
        vecs.push_back(vec_t'{4, 1'b1, 8'h8,  8'h7,  16'h00C8});
        vecs.push_back(vec_t'{4, 1'b1, 8'hF,  8'hF,  16'h0001});
        vecs.push_back(vec_t'{4, 1'b1, 8'hF,  8'h7,  16'h00F9});
        vecs.push_back(vec_t'{4, 1'b1, 8'h0,  8'hB,  16'h0000});
        vecs.push_back(vec_t'{4, 1'b1, 8'h7,  8'h7,  16'h0031});
        vecs.push_back(vec_t'{8, 1'b0, 8'd255, 8'd255, 16'hFE01});
        vecs.push_back(vec_t'{8, 1'b0, 8'd200, 8'd3,   16'h0258});
        vecs.push_back(vec_t'{8, 1'b1, 8'h80,  8'h80,  16'h4000});
        vecs.push_back(vec_t'{8, 1'b1, 8'hFF,  8'h7F,  16'hFF81});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_busy4", 32'(busy4), 32'd0);
        check("reset_done4", 32'(done4), 32'd0);
        check("reset_prod4", 32'(prod4), 32'd0);
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_prod8", 32'(prod8), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, p, edges, busy_n);
            check($sformatf("product_%0d", i), 32'(p), 32'(vecs[i].exp));
            check($sformatf("latency_%0d", i), 32'(edges), 32'(vecs[i].w + 1));
            check($sformatf("busy_cycles_%0d", i), 32'(busy_n), 32'(vecs[i].w));
        end

        // start held high: operands changed mid-op, second op only after FINISH->IDLE
        @(negedge clk);
        sm4 = 1'b0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd7;
        n = 0;
        while (!done4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_first_done", 32'(done4), 32'd1);
        check("held_first_prod", 32'(prod4), 32'd15);
        @(negedge clk);
        check("held_gap_busy", 32'(busy4), 32'd0);
        check("held_gap_prod", 32'(prod4), 32'd15);
        @(negedge clk);
        check("held_second_busy", 32'(busy4), 32'd1);
        n = 0;
        held_bad = 0;
        while (!done4 && n < 40) begin
            if (prod4 !== 8'd15) held_bad++;
            @(negedge clk);
            n++;
        end
        start4 = 1'b0;
        check("held_prod_stable", 32'(held_bad), 32'd0);
        check("held_second_prod", 32'(prod4), 32'd49);
        check("held_second_latency", 32'(n), 32'd4);

        // Reset during the 2nd CALC cycle of 9x9
        @(negedge clk);
        @(negedge clk);
        sm4 = 1'b0; a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_prod", 32'(prod4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4) done_seen++;
        end
        check("rst_no_done", 32'(done_seen), 32'd0);
        run_op(4, 1'b0, 8'd2, 8'd3, p, edges, busy_n);
        check("after_rst_prod", 32'(p), 32'd6);
        check("after_rst_latency", 32'(edges), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
